mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one fixed_mult.
REQ-002 SHALL have parameter WIDTH, default 17, operand/result width in fixed_mult format.
REQ-003 SHALL have parameter MULT_LAT, default 1, clock cycles from mult_a/mult_b to mult_ab/clip flags.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request; held high with operands until granted.
REQ-007 req_a  input  NREQ*WIDTH  operand A per requester, slice i = requester i.
REQ-008 req_b  input  NREQ*WIDTH  operand B per requester.
REQ-009 gnt  output  NREQ  one-hot grant, combinational from req and priority pointer.
REQ-010 mult_a  output  WIDTH  registered operand A to fixed_mult.a.
REQ-011 mult_b  output  WIDTH  registered operand B to fixed_mult.b.
REQ-012 mult_ab  input  WIDTH  product from fixed_mult.ab.
REQ-013 mult_clip_int  input  1  integer-overflow clip flag from fixed_mult.
REQ-014 mult_clip_frac  input  1  fraction-underflow clip flag from fixed_mult.
REQ-015 rsp_valid  output  1  registered; result for rsp_id valid this cycle.
REQ-016 rsp_id  output  clog2(NREQ)  index of requester owning the result.
REQ-017 rsp_ab  output  WIDTH  registered product.
REQ-018 rsp_clip  output  2  registered {clip_int, clip_frac} for the result.
REQ-019 clip_sticky  output  NREQ  per-requester OR of all clip flags since reset/clear.
REQ-020 clip_clr  input  1  clears clip_sticky (single cycle pulse).

Function
REQ-021 Arbitration SHALL be round-robin: search starts at requester ptr, wraps NREQ-1 -> 0; first asserted req wins.
REQ-022 At most one gnt bit SHALL be high per cycle; gnt SHALL be zero when req is zero or rst is high.
REQ-023 On a grant edge to requester k, ptr SHALL become (k+1) mod NREQ; with no grant, ptr SHALL hold.
REQ-024 Grant in cycle t SHALL register req_a/req_b slice k into mult_a/mult_b, valid in cycle t+1.
REQ-025 An issue-valid/tag shift register of depth MULT_LAT+1 SHALL track k alongside the operand.
REQ-026 mult_ab and clip flags SHALL be sampled in cycle t+1+MULT_LAT; rsp_* SHALL be valid in cycle t+2+MULT_LAT (t+3 at default).
REQ-027 Throughput SHALL be one issue per cycle; back-to-back grants SHALL never stall or drop results.
REQ-028 Results SHALL return in issue order; rsp_id SHALL equal the granted index.
REQ-029 Cycles with no grant SHALL drive mult_a/mult_b to zero and produce no rsp_valid.
REQ-030 On rsp_valid, clip_sticky[rsp_id] SHALL OR in |rsp_clip on the following edge.
REQ-031 clip_clr and a same-cycle sticky set SHALL resolve to set (set wins).
REQ-032 A requester dropping req before grant SHALL be treated as withdrawn; no result issued.

Reset
REQ-033 While rst is high: ptr=0, mult_a=0, mult_b=0, pipeline valids=0, rsp_valid=0, rsp_id=0, rsp_ab=0, rsp_clip=0, clip_sticky=0.
REQ-034 Reset mid-operation SHALL discard all in-flight results; no rsp_valid in the cycle after rst deasserts for operations issued before reset.
REQ-035 After reset, requester 0 SHALL hold highest priority.

Verification (bench drives mult_* from stub: mult_ab = mult_a + mult_b, clip_int = mult_a[16], clip_frac = mult_b[16], latency MULT_LAT)
REQ-036 Single: req=0001, a0=17'h00200, b0=17'h00200 -> gnt=0001 in cycle t, rsp_valid cycle t+3, rsp_id=0, rsp_ab=17'h00400, rsp_clip=00.
REQ-037 All four held continuously, a_i=i, b_i=16 -> grants 0,1,2,3,0 in consecutive cycles; rsp_ab 16,17,18,19 with rsp_id 0..3 back-to-back.
REQ-038 ptr=2 after grant to 1, req=1011 -> next grant requester 3, then 0, then 1 (wrap-around).
REQ-039 Requester 2 with a2=17'h10000 -> rsp_clip=10, clip_sticky=0100; clip_clr pulse -> clip_sticky=0000; clr coincident with new clip -> stays 0100.
REQ-040 Grants in cycles t, t+1, rst high in cycle t+2 -> no rsp_valid in cycles t+2..t+5; post-reset req=1000 -> gnt=1000, ptr becomes 0.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that time-shares one fixed_mult between NREQ requesters,
// tracking each issued operation's owner through the multiplier latency.
module mult_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 17,
  parameter int MULT_LAT = 1,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        mult_a,
  output logic [WIDTH-1:0]        mult_b,
  input  logic [WIDTH-1:0]        mult_ab,
  input  logic                    mult_clip_int,
  input  logic                    mult_clip_frac,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_ab,
  output logic [1:0]              rsp_clip,
  output logic [NREQ-1:0]         clip_sticky,
  input  logic                    clip_clr
);

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  int               idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [MULT_LAT:0] vld_pipe;
  logic [IDW-1:0]   tag_pipe [MULT_LAT+1];
  logic [NREQ-1:0]  sticky_set;

  // Search from ptr upward with wrap; the first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = int'(ptr) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = IDW'(idx);
        end
      end
    end
  end

  // AND-OR operand mux; yields zero operands when nothing is granted.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      mult_a <= '0;
      mult_b <= '0;
    end else begin
      if (gnt_any) ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      mult_a <= sel_a;
      mult_b <= sel_b;
    end
  end

  // Stage 0 lines up with mult_a/mult_b; stage MULT_LAT lines up with mult_ab.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 0; s <= MULT_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      vld_pipe[0] <= gnt_any;
      tag_pipe[0] <= gnt_idx;
      for (int s = 1; s <= MULT_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_ab    <= '0;
      rsp_clip  <= '0;
    end else begin
      rsp_valid <= vld_pipe[MULT_LAT];
      rsp_id    <= vld_pipe[MULT_LAT] ? tag_pipe[MULT_LAT] : '0;
      rsp_ab    <= vld_pipe[MULT_LAT] ? mult_ab : '0;
      rsp_clip  <= vld_pipe[MULT_LAT] ? {mult_clip_int, mult_clip_frac} : 2'b00;
    end
  end

  always_comb begin
    sticky_set = '0;
    for (int i = 0; i < NREQ; i++) begin
      sticky_set[i] = rsp_valid && (|rsp_clip) && (rsp_id == IDW'(i));
    end
  end

  // A clear coinciding with a new clip keeps the new bit set.
  always_ff @(posedge clk) begin
    if (rst) clip_sticky <= '0;
    else     clip_sticky <= (clip_clr ? '0 : clip_sticky) | sticky_set;
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with an adder stub standing in for fixed_mult
// and a transaction-level reference model (queue of expected responses).
module tb_mult_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 17;
  localparam int MULT_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      mult_a;
  logic [WIDTH-1:0]      mult_b;
  logic [WIDTH-1:0]      mult_ab;
  logic                  mult_clip_int;
  logic                  mult_clip_frac;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_ab;
  logic [1:0]            rsp_clip;
  logic [NREQ-1:0]       clip_sticky;
  logic                  clip_clr;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .mult_a(mult_a), .mult_b(mult_b), .mult_ab(mult_ab),
    .mult_clip_int(mult_clip_int), .mult_clip_frac(mult_clip_frac),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ab(rsp_ab), .rsp_clip(rsp_clip),
    .clip_sticky(clip_sticky), .clip_clr(clip_clr)
  );

  always #5 clk = ~clk;

  // Multiplier stub: one cycle of latency, sum instead of product.
  always @(posedge clk) begin
    mult_ab        <= mult_a + mult_b;
    mult_clip_int  <= mult_a[WIDTH-1];
    mult_clip_frac <= mult_b[WIDTH-1];
  end

  typedef struct {
    int               id;
    logic [WIDTH-1:0] ab;
    logic [1:0]       clip;
    int               due;
  } rsp_t;

  rsp_t             exp_q[$];
  int               m_ptr;
  int               cyc;
  int               checks;
  int               failures;
  logic [NREQ-1:0]  m_sticky;
  logic             exp_valid;
  int               exp_id;
  logic [WIDTH-1:0] exp_ab;
  logic [1:0]       exp_clip;
  logic [WIDTH-1:0] exp_ma;
  logic [WIDTH-1:0] exp_mb;

  function automatic int rr_pick();
    if (rst) return -1;
    for (int i = 0; i < NREQ; i++)
      if (req[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(int k);
    logic [NREQ-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(int k, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask

  // Advance one clock and update the reference model; ends on the falling edge.
  task automatic tick();
    int k;
    rsp_t r;
    logic [WIDTH-1:0] la, lb;
    k = rr_pick();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0;
      exp_q.delete();
      m_sticky = '0;
      exp_ma = '0;
      exp_mb = '0;
    end else begin
      if (clip_clr) m_sticky = '0;
      if (exp_valid && (exp_clip != 2'b00)) m_sticky[exp_id] = 1'b1;
      exp_ma = '0;
      exp_mb = '0;
      if (k >= 0) begin
        la = req_a[k*WIDTH +: WIDTH];
        lb = req_b[k*WIDTH +: WIDTH];
        r.id = k;
        r.ab = la + lb;
        r.clip = {la[WIDTH-1], lb[WIDTH-1]};
        r.due = cyc + 2 + MULT_LAT;
        exp_q.push_back(r);
        exp_ma = la;
        exp_mb = lb;
        m_ptr = (k + 1) % NREQ;
      end
    end
    cyc++;
    @(negedge clk);
    exp_valid = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      exp_valid = 1'b1;
      exp_id = r.id;
      exp_ab = r.ab;
      exp_clip = r.clip;
    end
  endtask

  task automatic drain();
    req = '0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'($urandom);
    for (int i = 0; i < NREQ; i++) set_ops(i, 17'($urandom) & 17'h0FFFF, 17'($urandom) & 17'h0FFFF);
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt got=%b exp=0000", gnt); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("[TB] FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_ab !== 17'd0) begin failures++; $display("[TB] FAIL reset_rsp_ab got=%h exp=0", rsp_ab); end
    checks++; if (rsp_clip !== 2'b00) begin failures++; $display("[TB] FAIL reset_rsp_clip got=%b exp=00", rsp_clip); end
    checks++; if (mult_a !== 17'd0 || mult_b !== 17'd0) begin failures++; $display("[TB] FAIL reset_mult got=%h/%h exp=0/0", mult_a, mult_b); end
    checks++; if (clip_sticky !== 4'b0000) begin failures++; $display("[TB] FAIL reset_sticky got=%b exp=0000", clip_sticky); end
    rst = 1'b0;
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL reset_priority got=%b exp=0001", gnt); end
    tick();
    drain();
  endtask

  task automatic test_single();
    req = 4'b0001;
    set_ops(0, 17'h00200, 17'h00200);
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL single_gnt got=%b exp=0001", gnt); end
    tick();
    req = '0;
    checks++; if (mult_a !== 17'h00200 || mult_b !== 17'h00200) begin failures++; $display("[TB] FAIL single_mult got=%h/%h exp=00200/00200", mult_a, mult_b); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early1 got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (mult_a !== 17'h0 || mult_b !== 17'h0) begin failures++; $display("[TB] FAIL idle_mult got=%h/%h exp=0/0", mult_a, mult_b); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early2 got=%b exp=0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0 || rsp_ab !== 17'h00400 || rsp_clip !== 2'b00)
      begin failures++; $display("[TB] FAIL single_rsp got=id%0d ab%h clip%b exp=id0 ab00400 clip00", rsp_id, rsp_ab, rsp_clip); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_extra got=%b exp=0", rsp_valid); end
    drain();
  endtask

  task automatic test_back_to_back();
    req = 4'b1000;
    tick();
    drain();
    for (int i = 0; i < NREQ; i++) set_ops(i, 17'(i), 17'd16);
    for (int c = 0; c < 8; c++) begin
      req = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 5) begin
        checks++; if (gnt !== onehot(c % 4)) begin failures++; $display("[TB] FAIL b2b_gnt%0d got=%b exp=%b", c, gnt, onehot(c % 4)); end
      end
      tick();
      if (c >= 2 && c <= 6) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_ab !== 17'(16 + (c - 2) % 4)) begin
          failures++;
          $display("[TB] FAIL b2b_rsp%0d got=v%b id%0d ab%0d exp=v1 id%0d ab%0d", c, rsp_valid, rsp_id, rsp_ab, (c - 2) % 4, 16 + (c - 2) % 4);
        end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle%0d got=%b exp=0", c, rsp_valid); end
      end
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] seq [3];
    seq[0] = 4'b1000; seq[1] = 4'b0001; seq[2] = 4'b0010;
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL wrap_first got=%b exp=0010", gnt); end
    tick();
    req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gnt !== seq[i]) begin failures++; $display("[TB] FAIL wrap_gnt%0d got=%b exp=%b", i, gnt, seq[i]); end
      tick();
    end
    drain();
  endtask

  task automatic test_clip();
    logic found;
    req = 4'b0100;
    set_ops(2, 17'h10000, 17'h00005);
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL clip_gnt got=%b exp=0100", gnt); end
    tick();
    req = '0;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      tick();
      if (rsp_valid === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL clip_timeout got=none exp=rsp_valid"); end
    if (found) begin
      checks++; if (rsp_clip !== 2'b10 || rsp_id !== 2'd2) begin failures++; $display("[TB] FAIL clip_rsp got=clip%b id%0d exp=clip10 id2", rsp_clip, rsp_id); end
    end
    tick();
    checks++; if (clip_sticky !== 4'b0100) begin failures++; $display("[TB] FAIL clip_sticky_set got=%b exp=0100", clip_sticky); end
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    checks++; if (clip_sticky !== 4'b0000) begin failures++; $display("[TB] FAIL clip_clear got=%b exp=0000", clip_sticky); end
    req = 4'b0100;
    tick();
    req = '0;
    tick();
    tick();
    clip_clr = 1'b1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL clip_second_valid got=%b exp=1", rsp_valid); end
    tick();
    clip_clr = 1'b0;
    checks++; if (clip_sticky !== 4'b0100) begin failures++; $display("[TB] FAIL clip_set_wins got=%b exp=0100", clip_sticky); end
    drain();
  endtask

  task automatic test_reset_midop();
    req = 4'b0011;
    for (int i = 0; i < NREQ; i++) set_ops(i, 17'(100 + i), 17'(7));
    #1;
    checks++; if (gnt !== onehot(rr_pick())) begin failures++; $display("[TB] FAIL midop_gnt got=%b exp=%b", gnt, onehot(rr_pick())); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_rst got=gnt%b v%b exp=gnt0000 v0", gnt, rsp_valid); end
    tick();
    rst = 1'b0;
    req = 4'b1000;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_flush3 got=%b exp=0", rsp_valid); end
    checks++; if (gnt !== 4'b1000) begin failures++; $display("[TB] FAIL midop_post_gnt got=%b exp=1000", gnt); end
    tick();
    req = 4'b1001;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_flush4 got=%b exp=0", rsp_valid); end
    checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL midop_ptr0 got=%b exp=0001", gnt); end
    tick();
    req = '0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_flush5 got=%b exp=0", rsp_valid); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req = 4'($urandom);
      clip_clr = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        set_ops(i, 17'($urandom) & (($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'h0FFFF),
                   17'($urandom) & (($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'h0FFFF));
      end
      #1;
      checks++; if (gnt !== onehot(rr_pick())) begin failures++; $display("[TB] FAIL rnd_gnt c%0d got=%b exp=%b", c, gnt, onehot(rr_pick())); end
      tick();
      checks++; if (rsp_valid !== exp_valid) begin failures++; $display("[TB] FAIL rnd_valid c%0d got=%b exp=%b", c, rsp_valid, exp_valid); end
      if (exp_valid) begin
        checks++;
        if (rsp_id !== 2'(exp_id) || rsp_ab !== exp_ab || rsp_clip !== exp_clip) begin
          failures++;
          $display("[TB] FAIL rnd_rsp c%0d got=id%0d ab%h clip%b exp=id%0d ab%h clip%b", c, rsp_id, rsp_ab, rsp_clip, exp_id, exp_ab, exp_clip);
        end
      end
      checks++; if (mult_a !== exp_ma || mult_b !== exp_mb) begin failures++; $display("[TB] FAIL rnd_mult c%0d got=%h/%h exp=%h/%h", c, mult_a, mult_b, exp_ma, exp_mb); end
      checks++; if (clip_sticky !== m_sticky) begin failures++; $display("[TB] FAIL rnd_sticky c%0d got=%b exp=%b", c, clip_sticky, m_sticky); end
    end
    clip_clr = 1'b0;
    drain();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    m_ptr = 0;
    m_sticky = '0;
    exp_valid = 1'b0;
    exp_id = 0;
    exp_ab = '0;
    exp_clip = '0;
    exp_ma = '0;
    exp_mb = '0;
    rst = 1'b1;
    req = '0;
    req_a = '0;
    req_b = '0;
    clip_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_clip();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
